// File: rtl/alpha_blend_pkg.sv
// Shared types and helpers for the two-layer alpha blend engine.
package alpha_blend_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD0,
    CAP0,
    RD1,
    CAP1,
    CALC,
    WR,
    NEXT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    BLEND = 2'b00,
    KEYED = 2'b01,
    COPY0 = 2'b10,
    COPY1 = 2'b11
  } blend_mode_t;

  // Room for c0*a + c1*(S-a) + S/2 with an 8-bit colour and a (ALPHA_BITS+1)-bit weight.
  function automatic int lane_width(input int alpha_bits);
    return 8 + alpha_bits + 1;
  endfunction

endpackage

// File: rtl/alpha_blend_engine_if.sv
// SRAM port bundle between the blend engine (master) and the shared SRAM (slave).
interface alpha_blend_engine_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 1536
);
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] write_data;

  modport master (
    output read_enable, write_enable, address, write_data,
    input  read_data
  );

  modport slave (
    input  read_enable, write_enable, address, write_data,
    output read_data
  );
endinterface

// File: rtl/alpha_blend_lane.sv
// Combinational single-byte compositor lane: blend, colour-keyed, or straight copy.
module alpha_blend_lane
  import alpha_blend_pkg::*;
#(
  parameter int ALPHA_BITS = 4
) (
  input  logic [7:0]          c0,
  input  logic [7:0]          c1,
  input  logic [ALPHA_BITS:0] alpha,
  input  logic [7:0]          key,
  input  blend_mode_t         mode,
  output logic [7:0]          result
);
  localparam int W = lane_width(ALPHA_BITS);
  localparam int S = 1 << ALPHA_BITS;

  logic [W-1:0] mix;
  logic [7:0]   blended;

  // alpha is already clamped to S, so S-alpha never underflows and the sum stays below 256*S.
  always_comb begin
    mix     = W'(c0) * W'(alpha) + W'(c1) * (W'(S) - W'(alpha)) + W'(S / 2);
    blended = 8'(mix >> ALPHA_BITS);
    result  = blended;
    case (mode)
      BLEND: result = blended;
      KEYED: begin
        if (c0 == key)      result = c1;
        else if (c1 == key) result = c0;
        else                result = blended;
      end
      COPY0: result = c0;
      COPY1: result = c1;
      default: result = blended;
    endcase
  end

endmodule

// File: rtl/alpha_blend_engine.sv
// Two-layer compositor: reads a burst from each layer buffer, blends per byte lane,
// writes the blended burst to the output buffer, and repeats across the frame.
module alpha_blend_engine
  import alpha_blend_pkg::*;
#(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int WORD_SIZE_BYTES = 3,
  parameter int DATA_SIZE_WORDS = 64,
  parameter int ALPHA_BITS      = 4,
  parameter int FRAME_WORDS     = 65536,
  parameter int SRC0_BASE       = 0,
  parameter int SRC1_BASE       = 65536,
  parameter int DST_BASE        = 143360,
  parameter int RD_LATENCY      = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  blend_start,
  input  logic                  blend_abort,
  input  logic [1:0]            blend_mode,
  input  logic [ALPHA_BITS:0]   alpha_value,
  input  logic [7:0]            key_color,
  output logic                  blend_busy,
  output logic                  blend_done,
  alpha_blend_engine_if.master  sram
);
  localparam int B     = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8;
  localparam int LANES = B / 8;
  localparam int S     = 1 << ALPHA_BITS;
  localparam int LAT_W = $clog2(RD_LATENCY) + 1;

  localparam logic [ADDR_SIZE_BITS-1:0] STEP     = ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
  localparam logic [ADDR_SIZE_BITS-1:0] LAST_OFS = ADDR_SIZE_BITS'(FRAME_WORDS - DATA_SIZE_WORDS);
  localparam logic [ADDR_SIZE_BITS-1:0] SRC0_A   = ADDR_SIZE_BITS'(SRC0_BASE);
  localparam logic [ADDR_SIZE_BITS-1:0] SRC1_A   = ADDR_SIZE_BITS'(SRC1_BASE);
  localparam logic [ADDR_SIZE_BITS-1:0] DST_A    = ADDR_SIZE_BITS'(DST_BASE);
  localparam logic [LAT_W-1:0]          RD_LAST  = LAT_W'(RD_LATENCY - 1);
  localparam logic [LAT_W-1:0]          WR_LAST  = LAT_W'(1);
  localparam logic [ALPHA_BITS:0]       ALPHA_S  = (ALPHA_BITS + 1)'(S);

  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("alpha_blend_engine: RD_LATENCY must be at least 1");
  end
  if (DATA_SIZE_WORDS < 1 || FRAME_WORDS < DATA_SIZE_WORDS ||
      (FRAME_WORDS % DATA_SIZE_WORDS) != 0) begin : g_bad_frame
    $error("alpha_blend_engine: FRAME_WORDS must be a non-zero multiple of DATA_SIZE_WORDS");
  end
  if (ALPHA_BITS < 1 || WORD_SIZE_BYTES < 1) begin : g_bad_width
    $error("alpha_blend_engine: ALPHA_BITS and WORD_SIZE_BYTES must be at least 1");
  end

  state_t                    state;
  logic [ADDR_SIZE_BITS-1:0] offset;
  logic [LAT_W-1:0]          lat;
  blend_mode_t               mode_q;
  logic [ALPHA_BITS:0]       alpha_q;
  logic [7:0]                key_q;
  logic [B-1:0]              data0;
  logic [B-1:0]              data1;
  logic [B-1:0]              blend_word;
  logic [B-1:0]              lanes;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    alpha_blend_lane #(.ALPHA_BITS(ALPHA_BITS)) u_lane (
      .c0     (data0[8*j +: 8]),
      .c1     (data1[8*j +: 8]),
      .alpha  (alpha_q),
      .key    (key_q),
      .mode   (mode_q),
      .result (lanes[8*j +: 8])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      offset     <= '0;
      lat        <= '0;
      mode_q     <= BLEND;
      alpha_q    <= '0;
      key_q      <= '0;
      data0      <= '0;
      data1      <= '0;
      blend_word <= '0;
    end else if (blend_abort) begin
      // Abort outranks every transition; blend_word is deliberately left untouched.
      state <= IDLE;
      lat   <= '0;
    end else begin
      case (state)
        IDLE: if (blend_start) begin
          mode_q  <= blend_mode_t'(blend_mode);
          alpha_q <= (alpha_value > ALPHA_S) ? ALPHA_S : alpha_value;
          key_q   <= key_color;
          offset  <= '0;
          lat     <= '0;
          state   <= RD0;
        end
        RD0: if (lat == RD_LAST) begin
          lat   <= '0;
          state <= CAP0;
        end else lat <= lat + 1'b1;
        CAP0: begin
          data0 <= sram.read_data;
          state <= RD1;
        end
        RD1: if (lat == RD_LAST) begin
          lat   <= '0;
          state <= CAP1;
        end else lat <= lat + 1'b1;
        CAP1: begin
          data1 <= sram.read_data;
          state <= CALC;
        end
        CALC: begin
          blend_word <= lanes;
          state      <= WR;
        end
        WR: if (lat == WR_LAST) begin
          lat   <= '0;
          state <= NEXT;
        end else lat <= lat + 1'b1;
        NEXT: if (offset == LAST_OFS) state <= DONE;
        else begin
          offset <= offset + STEP;
          state  <= RD0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sram.read_enable  = 1'b0;
    sram.write_enable = 1'b0;
    sram.address      = '0;
    case (state)
      RD0: begin
        sram.read_enable = 1'b1;
        sram.address     = SRC0_A + offset;
      end
      RD1: begin
        sram.read_enable = 1'b1;
        sram.address     = SRC1_A + offset;
      end
      WR: begin
        sram.write_enable = 1'b1;
        sram.address      = DST_A + offset;
      end
      default: ;
    endcase
  end

  assign sram.write_data = blend_word;
  assign blend_busy      = (state != IDLE);
  assign blend_done      = (state == DONE);

endmodule

// File: tb/tb_alpha_blend_engine.sv
// Scoreboard bench for alpha_blend_engine with a latency-accurate SRAM model.
module tb_alpha_blend_engine;
  localparam int ADDR_W = 24;
  localparam int WSB    = 3;
  localparam int DSW    = 64;
  localparam int AB     = 4;
  localparam int FW     = 256;
  localparam int SRC0   = 0;
  localparam int SRC1   = 65536;
  localparam int DST    = 143360;
  localparam int RDL    = 2;
  localparam int B      = WSB * DSW * 8;
  localparam int LANES  = B / 8;
  localparam int NB     = FW / DSW;
  localparam int S      = 1 << AB;
  localparam int PASS_CYCLES = 1 + NB * (2 * RDL + 6);

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [B-1:0]      data;
  } wr_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          blend_start = 1'b0;
  logic          blend_abort = 1'b0;
  logic [1:0]    blend_mode = 2'b00;
  logic [AB:0]   alpha_value = '0;
  logic [7:0]    key_color = 8'h00;
  logic          blend_busy;
  logic          blend_done;

  alpha_blend_engine_if #(.ADDR_W(ADDR_W), .DATA_W(B)) sram_bus ();

  alpha_blend_engine #(
    .ADDR_SIZE_BITS (ADDR_W),
    .WORD_SIZE_BYTES(WSB),
    .DATA_SIZE_WORDS(DSW),
    .ALPHA_BITS     (AB),
    .FRAME_WORDS    (FW),
    .SRC0_BASE      (SRC0),
    .SRC1_BASE      (SRC1),
    .DST_BASE       (DST),
    .RD_LATENCY     (RDL)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .blend_start(blend_start),
    .blend_abort(blend_abort),
    .blend_mode (blend_mode),
    .alpha_value(alpha_value),
    .key_color  (key_color),
    .blend_busy (blend_busy),
    .blend_done (blend_done),
    .sram       (sram_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [B-1:0] layer0 [NB];
  logic [B-1:0] layer1 [NB];
  wr_t sb[$];
  wr_t cur;
  logic have_cur = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_burst(input string name, input logic [B-1:0] got, input logic [B-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      for (int unsigned j = 0; j < LANES; j++)
        if (got[8*j +: 8] !== exp[8*j +: 8]) begin
          $display("FAIL %s: lane %0d got=%02h expected=%02h", name, j, got[8*j +: 8], exp[8*j +: 8]);
          break;
        end
    end
  endtask

  function automatic logic [B-1:0] rand_burst();
    logic [B-1:0] v;
    for (int unsigned j = 0; j < LANES; j++) v[8*j +: 8] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [B-1:0] mem_read(input logic [ADDR_W-1:0] a);
    int o0 = int'(a) - SRC0;
    int o1 = int'(a) - SRC1;
    if (o0 >= 0 && o0 < FW && o0 % DSW == 0) return layer0[o0 / DSW];
    if (o1 >= 0 && o1 < FW && o1 % DSW == 0) return layer1[o1 / DSW];
    return rand_burst();
  endfunction

  // SRAM: data appears only after exactly RDL consecutive strobe cycles; noise otherwise.
  int unsigned rd_hold = 0;
  always @(posedge clk) begin
    if (sram_bus.read_enable) begin
      sram_bus.read_data <= (rd_hold == RDL - 1) ? mem_read(sram_bus.address) : rand_burst();
      rd_hold <= rd_hold + 1;
    end else begin
      sram_bus.read_data <= rand_burst();
      rd_hold <= 0;
    end
  end

  // Monitor: first cycle of each write strobe pops the next expected burst.
  initial begin
    logic prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (blend_done) done_cnt++;
      if (sram_bus.write_enable) begin
        if (!prev_we) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: address=%0h with empty scoreboard", sram_bus.address);
            have_cur = 1'b0;
          end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          chk("write_address", 64'(sram_bus.address), 64'(cur.addr));
          chk_burst("write_data", sram_bus.write_data, cur.data);
        end
      end
      prev_we = sram_bus.write_enable;
    end
  end

  function automatic int ref_lane(input int mode, input int a, input int key, input int c0, input int c1);
    int aa = (a > S) ? S : a;
    int bl = (c0 * aa + c1 * (S - aa) + S / 2) / S;
    case (mode)
      0: return bl;
      1: return (c0 == key) ? c1 : (c1 == key) ? c0 : bl;
      2: return c0;
      default: return c1;
    endcase
  endfunction

  task automatic expect_model(input int mode, input int a, input int key);
    wr_t w;
    for (int unsigned k = 0; k < NB; k++) begin
      w.addr = ADDR_W'(DST + int'(k) * DSW);
      for (int unsigned j = 0; j < LANES; j++)
        w.data[8*j +: 8] = 8'(ref_lane(mode, a, key, int'(layer0[k][8*j +: 8]), int'(layer1[k][8*j +: 8])));
      sb.push_back(w);
    end
  endtask

  task automatic fill_random(input logic inject, input logic [7:0] key);
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned j = 0; j < LANES; j++) begin
        layer0[k][8*j +: 8] = (inject && $urandom_range(0, 3) == 0) ? key : 8'($urandom);
        layer1[k][8*j +: 8] = (inject && $urandom_range(0, 3) == 0) ? key : 8'($urandom);
      end
  endtask

  task automatic start_pass(input logic [1:0] mode, input logic [AB:0] a, input logic [7:0] key);
    @(negedge clk);
    blend_mode  = mode;
    alpha_value = a;
    key_color   = key;
    blend_start = 1'b1;
    @(negedge clk);
    blend_start = 1'b0;
    blend_mode  = 2'($urandom);
    alpha_value = (AB + 1)'($urandom);
    key_color   = 8'($urandom);
    chk("first_read_enable", 64'(sram_bus.read_enable), 64'd1);
    chk("first_read_address", 64'(sram_bus.address), 64'(SRC0));
  endtask

  task automatic run_pass(input logic [1:0] mode, input logic [AB:0] a, input logic [7:0] key);
    int cyc;
    start_pass(mode, a, key);
    cyc = 1;
    while (!blend_done && cyc < 4 * PASS_CYCLES) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'(PASS_CYCLES));
    @(negedge clk);
    chk("done_single_cycle", 64'(blend_done), 64'd0);
    chk("idle_after_done", 64'(blend_busy), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(blend_busy), 64'd0);
    chk({tag, "_done"}, 64'(blend_done), 64'd0);
    chk({tag, "_read_enable"}, 64'(sram_bus.read_enable), 64'd0);
    chk({tag, "_write_enable"}, 64'(sram_bus.write_enable), 64'd0);
    chk({tag, "_address"}, 64'(sram_bus.address), 64'd0);
    chk_burst({tag, "_write_data"}, sram_bus.write_data, '0);
  endtask

  initial begin
    int cyc;
    int done_before;
    wr_t w;
    logic [7:0] key;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1'b1;

    // Uniform BLEND at half weight: (0x80*8 + 0x40*8 + 8) >> 4 = 0x60.
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned j = 0; j < LANES; j++) begin
        layer0[k][8*j +: 8] = 8'h80;
        layer1[k][8*j +: 8] = 8'h40;
      end
    for (int unsigned k = 0; k < NB; k++) begin
      w.addr = ADDR_W'(DST + int'(k) * DSW);
      w.data = {LANES{8'h60}};
      sb.push_back(w);
    end
    run_pass(2'b00, 5'd8, 8'h00);

    // KEYED directed pattern (FF,12) (34,FF) (FF,FF) (10,10) -> 12 34 FF 10.
    for (int unsigned k = 0; k < NB; k++)
      for (int unsigned j = 0; j < LANES; j++) begin
        case (j % 4)
          0: begin layer0[k][8*j +: 8] = 8'hFF; layer1[k][8*j +: 8] = 8'h12; end
          1: begin layer0[k][8*j +: 8] = 8'h34; layer1[k][8*j +: 8] = 8'hFF; end
          2: begin layer0[k][8*j +: 8] = 8'hFF; layer1[k][8*j +: 8] = 8'hFF; end
          default: begin layer0[k][8*j +: 8] = 8'h10; layer1[k][8*j +: 8] = 8'h10; end
        endcase
      end
    for (int unsigned k = 0; k < NB; k++) begin
      w.addr = ADDR_W'(DST + int'(k) * DSW);
      w.data = {LANES / 4{8'h10, 8'hFF, 8'h34, 8'h12}};
      sb.push_back(w);
    end
    run_pass(2'b01, 5'd8, 8'hFF);

    // Alpha extremes: clamped 20 -> layer0, 0 -> layer1.
    fill_random(1'b0, 8'h00);
    for (int unsigned k = 0; k < NB; k++) begin
      w.addr = ADDR_W'(DST + int'(k) * DSW); w.data = layer0[k]; sb.push_back(w);
    end
    run_pass(2'b00, 5'd20, 8'h00);
    for (int unsigned k = 0; k < NB; k++) begin
      w.addr = ADDR_W'(DST + int'(k) * DSW); w.data = layer1[k]; sb.push_back(w);
    end
    run_pass(2'b00, 5'd0, 8'h00);

    // Randomised passes over every mode against the reference model.
    for (int unsigned i = 0; i < 6; i++) begin
      int mode = int'(i % 4);
      int a = $urandom_range(0, 31);
      key = 8'($urandom);
      fill_random(mode == 1, key);
      expect_model(mode, a, int'(key));
      run_pass(2'(mode), (AB + 1)'(a), key);
    end

    // Abort in the first WR cycle of burst 2.
    fill_random(1'b0, 8'h00);
    expect_model(0, 5, 0);
    done_before = done_cnt;
    start_pass(2'b00, 5'd5, 8'h00);
    cyc = 0;
    while (!(sram_bus.write_enable && sram_bus.address == ADDR_W'(DST + DSW)) && cyc < 4 * PASS_CYCLES) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_burst2_write", 64'(sram_bus.write_enable), 64'd1);
    blend_abort = 1'b1;
    @(negedge clk);
    blend_abort = 1'b0;
    chk("abort_write_enable", 64'(sram_bus.write_enable), 64'd0);
    chk("abort_busy", 64'(blend_busy), 64'd0);
    chk_burst("abort_write_data_held", sram_bus.write_data, cur.data);
    repeat (2 * PASS_CYCLES) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(done_before));
    chk("abort_stays_idle", 64'(blend_busy), 64'd0);
    sb.delete();
    fill_random(1'b0, 8'h00);
    expect_model(3, 0, 0);
    run_pass(2'b11, 5'd0, 8'h00);

    // Reset asserted during RD1 of burst 3.
    fill_random(1'b0, 8'h00);
    expect_model(0, 11, 0);
    start_pass(2'b00, 5'd11, 8'h00);
    cyc = 0;
    while (!(sram_bus.read_enable && sram_bus.address == ADDR_W'(SRC1 + 2 * DSW)) && cyc < 4 * PASS_CYCLES) begin
      @(negedge clk);
      cyc++;
    end
    chk("reset_reached_burst3_rd1", 64'(sram_bus.read_enable), 64'd1);
    n_rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    @(negedge clk);
    n_rst = 1'b1;
    fill_random(1'b0, 8'h00);
    expect_model(2, 0, 0);
    run_pass(2'b10, 5'd0, 8'h00);

    // Start and abort together in IDLE.
    @(negedge clk);
    blend_start = 1'b1;
    blend_abort = 1'b1;
    @(negedge clk);
    blend_start = 1'b0;
    blend_abort = 1'b0;
    chk("start_abort_busy", 64'(blend_busy), 64'd0);
    chk("start_abort_read_enable", 64'(sram_bus.read_enable), 64'd0);
    repeat (3) @(negedge clk);
    chk("start_abort_still_idle", 64'(blend_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
